// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle instruction sequencer with fetch/decode/exec/mem/wb control
module instr_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [8:0]  instr,
    input  logic        alu_zero,
    input  logic        mem_ack,
    output logic [8:0]  ir,
    output logic [1:0]  op2_sel,
    output logic        reg_we,
    output logic        wb_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic        pc_inc,
    output logic        pc_branch,
    output logic        busy,
    output logic        done,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t state;
    state_t state_nx;

    logic       is_sys;
    logic       is_ld;
    logic       is_st;
    logic       is_brz;
    logic       is_halt;
    logic [1:0] op2_dec;
    logic       clear_ret;
    logic       halt_enter;

    // Instruction class decode from the latched word; system sub-ops live in ir[5:3].
    assign is_sys  = (ir[8:6] == 3'b111);
    assign is_ld   = is_sys && (ir[5:3] == 3'b000);
    assign is_st   = is_sys && (ir[5:3] == 3'b001);
    assign is_brz  = is_sys && (ir[5:3] == 3'b010);
    assign is_halt = is_sys && (ir[5:3] == 3'b111);

    // Operand-2 source per class; the system class never uses operand 2.
    always_comb begin
        op2_dec = 2'b00;
        if (!ir[8]) begin
            op2_dec = 2'b11;
        end else begin
            case (ir[7:6])
                2'b00:   op2_dec = 2'b00;
                2'b01:   op2_dec = 2'b10;
                2'b10:   op2_dec = 2'b01;
                default: op2_dec = 2'b00;
            endcase
        end
    end

    // State register; reset forces IDLE so every strobe drops immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and output decode; only alu_zero (EXEC) and mem_ack (MEM) reach outputs directly.
    always_comb begin
        state_nx   = state;
        op2_sel    = 2'b00;
        reg_we     = 1'b0;
        wb_sel     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        pc_inc     = 1'b0;
        pc_branch  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        clear_ret  = 1'b0;
        halt_enter = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx  = S_FETCH;
                    clear_ret = 1'b1;
                end
            end
            S_FETCH: begin
                busy     = 1'b1;
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                busy     = 1'b1;
                op2_sel  = op2_dec;
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                busy    = 1'b1;
                op2_sel = op2_dec;
                if (!is_sys) begin
                    state_nx = S_WB;
                end else if (is_ld || is_st) begin
                    state_nx = S_MEM;
                end else if (is_halt) begin
                    state_nx   = S_HALT;
                    halt_enter = 1'b1;
                end else begin
                    state_nx = S_FETCH;
                    if (is_brz && alu_zero) begin
                        pc_branch = 1'b1;
                    end else begin
                        pc_inc = 1'b1;
                    end
                end
            end
            S_MEM: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = is_st;
                if (mem_ack) begin
                    if (is_st) begin
                        state_nx = S_FETCH;
                        pc_inc   = 1'b1;
                    end else begin
                        state_nx = S_WB;
                    end
                end
            end
            S_WB: begin
                busy     = 1'b1;
                op2_sel  = op2_dec;
                reg_we   = 1'b1;
                wb_sel   = is_ld;
                pc_inc   = 1'b1;
                state_nx = S_FETCH;
            end
            S_HALT: begin
                done = 1'b1;
                if (start) begin
                    state_nx  = S_FETCH;
                    clear_ret = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Instruction register loads only at the end of FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= 9'h000;
        end else if (state == S_FETCH) begin
            ir <= instr;
        end
    end

    // Retired counter: one per PC advance and one for the halting instruction, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= 16'h0000;
        end else if (clear_ret) begin
            retired <= 16'h0000;
        end else if (pc_inc || pc_branch || halt_enter) begin
            retired <= retired + 16'h0001;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  instr;
    logic        alu_zero;
    logic        mem_ack;
    logic [8:0]  ir;
    logic [1:0]  op2_sel;
    logic        reg_we;
    logic        wb_sel;
    logic        mem_req;
    logic        mem_we;
    logic        pc_inc;
    logic        pc_branch;
    logic        busy;
    logic        done;
    logic [15:0] retired;

    int total = 0;
    int bad   = 0;
    int exp_ret;

    instr_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .instr     (instr),
        .alu_zero  (alu_zero),
        .mem_ack   (mem_ack),
        .ir        (ir),
        .op2_sel   (op2_sel),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .pc_inc    (pc_inc),
        .pc_branch (pc_branch),
        .busy      (busy),
        .done      (done),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; instr = 9'h000; alu_zero = 1'b0; mem_ack = 1'b0;
        #3;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b exp=0", done); end
        total++; if (ir !== 9'h000) begin bad++; $display("FAIL rst_ir got=%h exp=000", ir); end
        total++; if (retired !== 16'h0000) begin bad++; $display("FAIL rst_retired got=%h exp=0000", retired); end
        total++; if ({op2_sel, reg_we, mem_req, mem_we, pc_inc, pc_branch} !== 7'b0) begin bad++; $display("FAIL rst_strobes got=%b exp=0000000", {op2_sel, reg_we, mem_req, mem_we, pc_inc, pc_branch}); end
        tick();
        rst_n = 1'b1;
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_hold_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_ldi();
        instr = 9'h0A5; start = 1'b1;
        tick();
        start = 1'b0; exp_ret = 0;
        total++; if (busy !== 1'b1 || op2_sel !== 2'b00) begin bad++; $display("FAIL ldi_fetch got busy=%0b op2=%b exp busy=1 op2=00", busy, op2_sel); end
        tick();
        start = 1'b1;
        total++; if (ir !== 9'h0A5 || op2_sel !== 2'b11) begin bad++; $display("FAIL ldi_decode got ir=%h op2=%b exp ir=0a5 op2=11", ir, op2_sel); end
        tick();
        start = 1'b0;
        total++; if (op2_sel !== 2'b11 || reg_we !== 1'b0 || pc_inc !== 1'b0) begin bad++; $display("FAIL ldi_exec got op2=%b we=%0b inc=%0b exp 11/0/0", op2_sel, reg_we, pc_inc); end
        tick();
        total++; if ({op2_sel, reg_we, wb_sel, pc_inc, mem_req} !== 6'b111010) begin bad++; $display("FAIL ldi_wb got=%b exp=111010", {op2_sel, reg_we, wb_sel, pc_inc, mem_req}); end
        tick();
        exp_ret = 1;
        total++; if (retired !== 16'(exp_ret) || busy !== 1'b1 || reg_we !== 1'b0) begin bad++; $display("FAIL ldi_retire got ret=%0d busy=%0b we=%0b exp ret=%0d busy=1 we=0", retired, busy, reg_we, exp_ret); end
    endtask

    task automatic test_alu_imm();
        logic [8:0] vec [2];
        logic [1:0] sel [2];
        vec[0] = 9'b110100011; sel[0] = 2'b01;
        vec[1] = 9'b101000111; sel[1] = 2'b10;
        for (int k = 0; k < 2; k++) begin
            instr = vec[k];
            tick();
            total++; if (op2_sel !== sel[k]) begin bad++; $display("FAIL alu%0d_decode_op2 got=%b exp=%b", k, op2_sel, sel[k]); end
            tick();
            tick();
            total++; if (op2_sel !== sel[k] || reg_we !== 1'b1 || pc_inc !== 1'b1) begin bad++; $display("FAIL alu%0d_wb got op2=%b we=%0b inc=%0b exp op2=%b 1 1", k, op2_sel, reg_we, pc_inc, sel[k]); end
            tick();
            exp_ret++;
            total++; if (retired !== 16'(exp_ret) || op2_sel !== 2'b00) begin bad++; $display("FAIL alu%0d_retire got ret=%0d op2=%b exp ret=%0d op2=00", k, retired, op2_sel, exp_ret); end
        end
    endtask

    task automatic test_load();
        int req_cnt;
        instr = 9'b111000010;
        tick();
        tick();
        mem_ack = 1'b1;
        total++; if (mem_req !== 1'b0 || op2_sel !== 2'b00) begin bad++; $display("FAIL ld_exec got req=%0b op2=%b exp 0/00", mem_req, op2_sel); end
        tick();
        mem_ack = 1'b0;
        req_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ack = 1'b1;
            #1;
            if (mem_req === 1'b1) req_cnt++;
            total++; if (mem_we !== 1'b0 || pc_inc !== 1'b0 || reg_we !== 1'b0) begin bad++; $display("FAIL ld_mem%0d got we=%0b inc=%0b rwe=%0b exp 0/0/0", i, mem_we, pc_inc, reg_we); end
            tick();
        end
        mem_ack = 1'b0;
        total++; if (req_cnt !== 4) begin bad++; $display("FAIL ld_req_cycles got=%0d exp=4", req_cnt); end
        total++; if ({mem_req, reg_we, wb_sel, pc_inc} !== 4'b0111) begin bad++; $display("FAIL ld_wb got=%b exp=0111", {mem_req, reg_we, wb_sel, pc_inc}); end
        tick();
        exp_ret++;
        total++; if (retired !== 16'(exp_ret) || busy !== 1'b1 || reg_we !== 1'b0) begin bad++; $display("FAIL ld_retire got ret=%0d busy=%0b we=%0b exp ret=%0d 1 0", retired, busy, reg_we, exp_ret); end
    endtask

    task automatic test_store();
        instr = 9'b111001000;
        tick(); tick(); tick();
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || pc_inc !== 1'b0) begin bad++; $display("FAIL st_mem_wait got req=%0b we=%0b inc=%0b exp 1/1/0", mem_req, mem_we, pc_inc); end
        tick();
        mem_ack = 1'b1;
        #1;
        total++; if (pc_inc !== 1'b1 || mem_req !== 1'b1 || reg_we !== 1'b0) begin bad++; $display("FAIL st_mem_ack got inc=%0b req=%0b rwe=%0b exp 1/1/0", pc_inc, mem_req, reg_we); end
        tick();
        mem_ack = 1'b0;
        exp_ret++;
        total++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || retired !== 16'(exp_ret)) begin bad++; $display("FAIL st_after got req=%0b we=%0b ret=%0d exp 0/0/%0d", mem_req, mem_we, retired, exp_ret); end
    endtask

    task automatic test_branch();
        logic [8:0] vec [3];
        logic       az  [3];
        logic [1:0] exp [3];
        vec[0] = 9'b111010000; az[0] = 1'b1; exp[0] = 2'b01;
        vec[1] = 9'b111010000; az[1] = 1'b0; exp[1] = 2'b10;
        vec[2] = 9'b111011000; az[2] = 1'b1; exp[2] = 2'b10;
        for (int k = 0; k < 3; k++) begin
            instr = vec[k];
            alu_zero = 1'b1;
            tick();
            total++; if ({pc_inc, pc_branch} !== 2'b00) begin bad++; $display("FAIL br%0d_decode got=%b exp=00", k, {pc_inc, pc_branch}); end
            tick();
            alu_zero = az[k];
            #1;
            total++; if ({pc_inc, pc_branch} !== exp[k]) begin bad++; $display("FAIL br%0d_exec got=%b exp=%b", k, {pc_inc, pc_branch}, exp[k]); end
            tick();
            alu_zero = 1'b0;
            exp_ret++;
            total++; if (retired !== 16'(exp_ret) || {pc_inc, pc_branch} !== 2'b00 || busy !== 1'b1) begin bad++; $display("FAIL br%0d_fetch got ret=%0d strobes=%b busy=%0b exp ret=%0d 00 1", k, retired, {pc_inc, pc_branch}, busy, exp_ret); end
        end
    endtask

    task automatic test_halt();
        instr = 9'b111111000;
        tick(); tick(); tick();
        exp_ret++;
        total++; if (done !== 1'b1 || busy !== 1'b0 || retired !== 16'(exp_ret)) begin bad++; $display("FAIL halt_enter got done=%0b busy=%0b ret=%0d exp 1/0/%0d", done, busy, retired, exp_ret); end
        tick();
        total++; if (done !== 1'b1 || {pc_inc, pc_branch, reg_we, mem_req} !== 4'b0000) begin bad++; $display("FAIL halt_hold got done=%0b strobes=%b exp 1 0000", done, {pc_inc, pc_branch, reg_we, mem_req}); end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (retired !== 16'h0000 || busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL halt_restart got ret=%0d busy=%0b done=%0b exp 0/1/0", retired, busy, done); end
    endtask

    task automatic test_wrap();
        instr = 9'b111111000;
        tick();
        force dut.retired = 16'hFFFF;
        #1;
        release dut.retired;
        tick(); tick();
        total++; if (retired !== 16'h0000 || done !== 1'b1) begin bad++; $display("FAIL wrap got ret=%h done=%0b exp 0000 1", retired, done); end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (retired !== 16'h0000 || busy !== 1'b1) begin bad++; $display("FAIL wrap_restart got ret=%h busy=%0b exp 0000 1", retired, busy); end
    endtask

    task automatic test_reset_mid_mem();
        instr = 9'b111001000;
        tick(); tick(); tick(); tick();
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL rstmem_pre got req=%0b we=%0b exp 1/1", mem_req, mem_we); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmem_async got req=%0b we=%0b busy=%0b exp 0/0/0", mem_req, mem_we, busy); end
        total++; if (ir !== 9'h000 || retired !== 16'h0000) begin bad++; $display("FAIL rstmem_regs got ir=%h ret=%h exp 000 0000", ir, retired); end
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (busy !== 1'b0 || mem_req !== 1'b0 || pc_inc !== 1'b0) begin bad++; $display("FAIL rstmem_idle%0d got busy=%0b req=%0b inc=%0b exp 0/0/0", i, busy, mem_req, pc_inc); end
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_alu_imm();
        test_load();
        test_store();
        test_branch();
        test_halt();
        test_wrap();
        test_reset_mid_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
